idli_sqi_mem_m: RTL and testbench



---
 rtl/idli_sqi_mem_m.sv | 206 ++++++++++++++++++++
 tb/tb_idli_sqi_mem_m.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/idli_sqi_mem_m.sv
// SQI serial-SRAM emulator: decodes quad-mode READ/WRITE sequences from the core and serves them from a byte array.
// Optional `IDLI_SQI_MEM_MODE_EN adds the RDMR/WRMR mode register (BYTE/PAGE/SEQ address advance).
module idli_sqi_mem_m #(
  parameter int ADDR_NIB  = 6,
  parameter int DEPTH_W   = 12,
  parameter int DUMMY_NIB = 2
) (
  input  logic       i_mem_gck,
  input  logic       i_mem_rst,
  input  logic       i_mem_sck,
  input  logic       i_mem_cs,
  input  logic [3:0] i_mem_sio,
  output logic [3:0] o_mem_sio,
  output logic       o_mem_sio_oe,
  output logic       o_mem_err
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_CMD     = 4'd1;
  localparam logic [3:0] S_ADDR    = 4'd2;
  localparam logic [3:0] S_DUMMY   = 4'd3;
  localparam logic [3:0] S_RD      = 4'd4;
  localparam logic [3:0] S_WR      = 4'd5;
  localparam logic [3:0] S_MODE_RD = 4'd6;
  localparam logic [3:0] S_MODE_WR = 4'd7;
  localparam logic [3:0] S_IGNORE  = 4'd8;

  localparam logic [7:0] ADDR_LAST  = 8'(ADDR_NIB - 1);
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_NIB - 1);

  logic               r_sck_q;
  logic [3:0]         r_state;
  logic [DEPTH_W-1:0] r_addr;
  logic [7:0]         r_cnt;
  logic [3:0]         r_hi;
  logic               r_is_rd;
  logic               r_wr_done;
  logic [3:0]         r_sio;
  logic               r_oe;
  logic               r_err;
  logic [7:0]         r_mem [0:(1<<DEPTH_W)-1];

  logic               w_rise;
  logic               w_act;
  logic [1:0]         w_mode_sel;
  logic [DEPTH_W-1:0] w_next;
  logic [7:0]         w_rd_byte;
  logic [7:0]         w_rd_next;
  logic               w_we;

`ifdef IDLI_SQI_MEM_MODE_EN
  logic [7:0] r_mode;
  assign w_mode_sel = r_mode[7:6];
`else
  assign w_mode_sel = 2'b01;
`endif

  // BYTE holds, PAGE wraps inside 32 bytes, SEQ and reserved 11 increment linearly
  function automatic logic [DEPTH_W-1:0] f_next_addr(input logic [DEPTH_W-1:0] a,
                                                     input logic [1:0] m);
    case (m)
      2'b00:   return a;
      2'b10:   return {a[DEPTH_W-1:5], a[4:0] + 5'd1};
      default: return a + 1'b1;
    endcase
  endfunction

  assign w_rise    = i_mem_sck & ~r_sck_q;
  assign w_act     = w_rise & ~i_mem_cs;
  assign w_next    = f_next_addr(r_addr, w_mode_sel);
  assign w_rd_byte = r_mem[r_addr];
  assign w_rd_next = r_mem[w_next];
  assign w_we      = w_act & ~i_mem_rst & (r_state == S_WR) & (r_cnt == 8'd1)
                   & ~((w_mode_sel == 2'b00) & r_wr_done);

  assign o_mem_sio    = r_sio;
  assign o_mem_sio_oe = r_oe;
  assign o_mem_err    = r_err;

  always_ff @(posedge i_mem_gck) begin
    if (w_we) r_mem[r_addr] <= {r_hi, i_mem_sio};
  end

  always_ff @(posedge i_mem_gck) begin
    r_sck_q <= i_mem_sck;
    if (i_mem_rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_sio     <= '0;
      r_oe      <= 1'b0;
      r_err     <= 1'b0;
      r_wr_done <= 1'b0;
      r_is_rd   <= 1'b0;
`ifdef IDLI_SQI_MEM_MODE_EN
      r_mode    <= 8'h40;
`endif
    end else if (i_mem_cs) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_sio     <= '0;
      r_oe      <= 1'b0;
      r_wr_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_CMD;
          r_cnt   <= '0;
          if (w_rise) begin
            r_hi  <= i_mem_sio;
            r_cnt <= 8'd1;
          end
        end
        S_CMD: if (w_rise) begin
          if (r_cnt == 8'd0) begin
            r_hi  <= i_mem_sio;
            r_cnt <= 8'd1;
          end else begin
            r_cnt <= '0;
            case ({r_hi, i_mem_sio})
              8'h03: begin r_state <= S_ADDR; r_is_rd <= 1'b1; end
              8'h02: begin r_state <= S_ADDR; r_is_rd <= 1'b0; end
`ifdef IDLI_SQI_MEM_MODE_EN
              8'h05: begin
                r_state <= S_MODE_RD;
                r_oe    <= 1'b1;
                r_sio   <= r_mode[7:4];
              end
              8'h01: r_state <= S_MODE_WR;
`endif
              default: begin r_state <= S_IGNORE; r_err <= 1'b1; end
            endcase
          end
        end
        S_ADDR: if (w_rise) begin
          r_addr <= {r_addr[DEPTH_W-5:0], i_mem_sio};
          if (r_cnt == ADDR_LAST) begin
            r_cnt   <= '0;
            r_state <= r_is_rd ? S_DUMMY : S_WR;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DUMMY: if (w_rise) begin
          if (r_cnt == DUMMY_LAST) begin
            r_cnt   <= '0;
            r_state <= S_RD;
            r_oe    <= 1'b1;
            r_sio   <= w_rd_byte[7:4];
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        // r_cnt tracks which nibble is currently on the bus: 0 high, 1 low
        S_RD: if (w_rise) begin
          if (r_cnt == 8'd0) begin
            r_sio <= w_rd_byte[3:0];
            r_cnt <= 8'd1;
          end else begin
            r_sio  <= w_rd_next[7:4];
            r_addr <= w_next;
            r_cnt  <= '0;
          end
        end
        S_WR: if (w_rise) begin
          if (r_cnt == 8'd0) begin
            r_hi  <= i_mem_sio;
            r_cnt <= 8'd1;
          end else begin
            r_cnt     <= '0;
            r_addr    <= w_next;
            r_wr_done <= 1'b1;
          end
        end
        S_MODE_RD: begin
`ifdef IDLI_SQI_MEM_MODE_EN
          if (w_rise) begin
            r_sio <= (r_cnt == 8'd0) ? r_mode[3:0] : r_mode[7:4];
            r_cnt <= (r_cnt == 8'd0) ? 8'd1 : 8'd0;
          end
`else
          r_state <= S_IGNORE;
`endif
        end
        S_MODE_WR: begin
`ifdef IDLI_SQI_MEM_MODE_EN
          if (w_rise) begin
            if (r_cnt == 8'd0) begin
              r_hi  <= i_mem_sio;
              r_cnt <= 8'd1;
            end else begin
              r_mode  <= {r_hi, i_mem_sio};
              r_cnt   <= '0;
              r_state <= S_IGNORE;
            end
          end
`else
          r_state <= S_IGNORE;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Directed bench for idli_sqi_mem_m: write/read, address wrap, partial write, bad command, reset mid-read.
module tb_idli_sqi_mem_m;

  logic       clk = 1'b0;
  logic       rst;
  logic       sck;
  logic       cs;
  logic [3:0] sio;
  logic [3:0] o_sio;
  logic       o_oe;
  logic       o_err;
  logic [3:0] obs_sio;
  logic       obs_oe;
  int         n_checks = 0;
  int         n_errors = 0;

  idli_sqi_mem_m #(.ADDR_NIB(6), .DEPTH_W(12), .DUMMY_NIB(2)) u_dut (
    .i_mem_gck    (clk),
    .i_mem_rst    (rst),
    .i_mem_sck    (sck),
    .i_mem_cs     (cs),
    .i_mem_sio    (sio),
    .o_mem_sio    (o_sio),
    .o_mem_sio_oe (o_oe),
    .o_mem_err    (o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // one SCK period; obs_* hold what the core would sample at this rise
  task automatic sck_cycle(input logic [3:0] n);
    sio = n;
    sck = 1'b0;
    tick(2);
    obs_sio = o_sio;
    obs_oe  = o_oe;
    sck = 1'b1;
    tick(2);
  endtask

  task automatic send_byte(input logic [7:0] b);
    sck_cycle(b[7:4]);
    sck_cycle(b[3:0]);
  endtask

  task automatic txn_begin();
    sck = 1'b0;
    cs  = 1'b0;
    tick(1);
  endtask

  task automatic txn_end();
    sck = 1'b0;
    tick(1);
    cs = 1'b1;
    tick(2);
  endtask

  task automatic start_cmd(input logic [7:0] cmd, input logic [23:0] a);
    txn_begin();
    send_byte(cmd);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  task automatic rd_start(input logic [23:0] a);
    start_cmd(8'h03, a);
    sck_cycle(4'h0);
    sck_cycle(4'h0);
  endtask

  task automatic rd_expect(input string tag, input logic [7:0] exp);
    sck_cycle(4'h0);
    chk({tag, "_hi"}, obs_sio, exp[7:4]);
    chk({tag, "_oe"}, obs_oe, 1'b1);
    sck_cycle(4'h0);
    chk({tag, "_lo"}, obs_sio, exp[3:0]);
  endtask

  initial begin
    rst = 1'b1;
    cs  = 1'b1;
    sck = 1'b0;
    sio = 4'h0;
    obs_sio = 4'h0;
    obs_oe  = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_oe", o_oe, 1'b0);
    chk("rst_sio", o_sio, 4'h0);
    chk("rst_err", o_err, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sck_cycle(4'hF);
      chk("idle_oe", o_oe, 1'b0);
      chk("idle_sio", o_sio, 4'h0);
      chk("idle_err", o_err, 1'b0);
    end

    // write then read back two bytes
    start_cmd(8'h02, 24'h000010);
    send_byte(8'hA5);
    send_byte(8'h3C);
    txn_end();
    start_cmd(8'h03, 24'h000010);
    chk("addr_oe", o_oe, 1'b0);
    sck_cycle(4'h0);
    sck_cycle(4'h0);
    chk("dummy_oe", obs_oe, 1'b0);
    rd_expect("rd10", 8'hA5);
    rd_expect("rd11", 8'h3C);
    txn_end();
    chk("end_oe", o_oe, 1'b0);
    chk("end_sio", o_sio, 4'h0);

    // wrap at top of array
    start_cmd(8'h02, 24'h000FFF);
    send_byte(8'hFF);
    send_byte(8'h11);
    txn_end();
    rd_start(24'h000FFF);
    rd_expect("rdFFF", 8'hFF);
    rd_expect("rdwrap", 8'h11);
    txn_end();
    rd_start(24'h000000);
    rd_expect("rd000", 8'h11);
    txn_end();

    // partial byte dropped on cs rise
    start_cmd(8'h02, 24'h000020);
    send_byte(8'h5A);
    txn_end();
    start_cmd(8'h02, 24'h000020);
    sck_cycle(4'h7);
    txn_end();
    rd_start(24'h000020);
    rd_expect("partial", 8'h5A);
    txn_end();

    // unsupported command
    txn_begin();
    send_byte(8'h9F);
    send_byte(8'h00);
    chk("bad_oe", o_oe, 1'b0);
    chk("bad_err", o_err, 1'b1);
    txn_end();
    rd_start(24'h000010);
    rd_expect("after_bad", 8'hA5);
    txn_end();
    chk("err_sticky", o_err, 1'b1);

    // reset in the middle of a read
    rd_start(24'h000010);
    sck_cycle(4'h0);
    chk("mid_n0", obs_sio, 4'hA);
    sck_cycle(4'h0);
    chk("mid_n1", obs_sio, 4'h5);
    sck_cycle(4'h0);
    chk("mid_n2", obs_sio, 4'h3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_oe", o_oe, 1'b0);
    chk("midrst_sio", o_sio, 4'h0);
    chk("midrst_err", o_err, 1'b0);
    txn_end();
    rd_start(24'h000010);
    rd_expect("after_rst", 8'hA5);
    txn_end();

`ifdef IDLI_SQI_MEM_MODE_EN
    txn_begin();
    send_byte(8'h01);
    send_byte(8'h80);
    txn_end();
    start_cmd(8'h02, 24'h00003E);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    txn_end();
    rd_start(24'h00003E);
    rd_expect("pg3E", 8'h01);
    rd_expect("pg3F", 8'h02);
    rd_expect("pg20", 8'h03);
    txn_end();
    txn_begin();
    send_byte(8'h05);
    sck_cycle(4'h0);
    chk("rdmr0", obs_sio, 4'h8);
    sck_cycle(4'h0);
    chk("rdmr1", obs_sio, 4'h0);
    sck_cycle(4'h0);
    chk("rdmr2", obs_sio, 4'h8);
    sck_cycle(4'h0);
    chk("rdmr3", obs_sio, 4'h0);
    txn_end();
    chk("mode_err", o_err, 1'b0);
`else
    txn_begin();
    send_byte(8'h01);
    send_byte(8'h80);
    chk("wrmr_oe", o_oe, 1'b0);
    txn_end();
    chk("wrmr_err", o_err, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
